sprite_fetch: RTL and testbench

Sprite data-fetch stage between the VIC bus interface and the sprite sequencer. During each sprite's fetch slot it generates the p-access and s-access addresses, captures the pointer byte and the three data bytes from the data bus, and commits them atomically as one 24-bit shift word per sprite. The sprites block loads that word one dot4x tick later, on `phi_phase_start_davp1` of the `VIC_HS3` cycle.

---
 rtl/sprite_fetch_pkg.sv | 24 ++
 rtl/sprite_addr_gen.sv | 54 +++++
 rtl/sprite_fetch.sv | 122 ++++++++++++
 tb/tb_sprite_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_pkg.sv
// Shared VIC cycle-type codes and sprite count for the sprite fetch path.
package sprite_fetch_pkg;

   localparam int NUM_SPRITES = 8;

   localparam logic [3:0] VIC_LP    = 4'd0;
   localparam logic [3:0] VIC_LPI2  = 4'd1;
   localparam logic [3:0] VIC_LS2   = 4'd2;
   localparam logic [3:0] VIC_LR    = 4'd3;
   localparam logic [3:0] VIC_LG    = 4'd4;
   localparam logic [3:0] VIC_HS1   = 4'd5;
   localparam logic [3:0] VIC_HPI1  = 4'd6;
   localparam logic [3:0] VIC_HPI3  = 4'd7;
   localparam logic [3:0] VIC_HS3   = 4'd8;
   localparam logic [3:0] VIC_HRC   = 4'd9;
   localparam logic [3:0] VIC_HGC   = 4'd10;
   localparam logic [3:0] VIC_HGI   = 4'd11;
   localparam logic [3:0] VIC_HIDLE = 4'd12;

   function automatic logic is_scycle(input logic [3:0] ct);
      return (ct == VIC_HS1) || (ct == VIC_LS2) || (ct == VIC_HS3);
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite p-access / s-access address mux with its output register.
module sprite_addr_gen
#(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    cycle_type,
   input  logic [CW-1:0] sprite_cnt,
   input  logic          dma,
   input  logic [7:0]    ptr,
   input  logic [5:0]    mc,
   input  logic [3:0]    vm,
   output logic [13:0]   addr,
   output logic          addr_valid
);
   import sprite_fetch_pkg::*;

   logic [13:0] addr_nx;
   logic        valid_nx;
   logic        lp;
   logic        s_on;

   assign lp   = (cycle_type == VIC_LP);
   assign s_on = is_scycle(cycle_type) && dma;

   // Address holds across non-fetch cycles; only valid flags activity.
   always_comb begin
      addr_nx  = addr;
      valid_nx = 1'b0;
      unique case (1'b1)
         lp: begin
            addr_nx  = 14'({vm, 7'h7F, sprite_cnt});
            valid_nx = 1'b1;
         end
         s_on: begin
            addr_nx  = {ptr, mc};
            valid_nx = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr       <= '0;
         addr_valid <= 1'b0;
      end else begin
         addr       <= addr_nx;
         addr_valid <= valid_nx;
      end
   end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite fetch stage: pointer/data capture and atomic 24-bit commit.
module sprite_fetch
#(
   parameter int NUM_SPRITES = sprite_fetch_pkg::NUM_SPRITES
) (
   input  logic                            clk_dot4x,
   input  logic                            rst_n,
   input  logic [3:0]                      cycle_type,
   input  logic [$clog2(NUM_SPRITES)-1:0]  sprite_cnt,
   input  logic                            phi_phase_start_dav,
   input  logic [NUM_SPRITES-1:0]          sprite_dma,
   input  logic [6*NUM_SPRITES-1:0]        sprite_mc,
   input  logic [3:0]                      vm,
   input  logic [7:0]                      dbi,
   output logic [13:0]                     sprite_addr,
   output logic                            sprite_addr_valid,
   output logic [8*NUM_SPRITES-1:0]        sprite_ptr,
   output logic [24*NUM_SPRITES-1:0]       sprite_pixels,
   output logic [NUM_SPRITES-1:0]          fetch_done,
   output logic                            fetch_seq_err
);
   import sprite_fetch_pkg::*;

   localparam int CW = $clog2(NUM_SPRITES);

   typedef enum logic [1:0] {IDLE, PTR, B0, B1} state_t;

   state_t        state;
   logic [CW-1:0] cur;
   logic [23:8]   stage;
   logic [7:0]    ptr_q [NUM_SPRITES];
   logic [23:0]   pix_q [NUM_SPRITES];
   logic [5:0]    mc_a  [NUM_SPRITES];

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
      assign sprite_ptr[g*8 +: 8]     = ptr_q[g];
      assign sprite_pixels[g*24 +: 24] = pix_q[g];
      assign mc_a[g]                  = sprite_mc[g*6 +: 6];
   end

   sprite_addr_gen #(.CW(CW)) u_addr (
      .clk        (clk_dot4x),
      .rst_n      (rst_n),
      .cycle_type (cycle_type),
      .sprite_cnt (sprite_cnt),
      .dma        (sprite_dma[sprite_cnt]),
      .ptr        (ptr_q[sprite_cnt]),
      .mc         (mc_a[sprite_cnt]),
      .vm         (vm),
      .addr       (sprite_addr),
      .addr_valid (sprite_addr_valid)
   );

   logic dma_on, s_cyc, same;
   logic lp, idle_f, s_off, hs1_ok, ls2_ok, hs3_ok, s_bad;

   assign dma_on = sprite_dma[sprite_cnt];
   assign s_cyc  = is_scycle(cycle_type);
   assign same   = (sprite_cnt == cur);
   assign lp     = (cycle_type == VIC_LP);
   assign idle_f = (cycle_type == VIC_LPI2) ||
                   (cycle_type == VIC_HPI3);
   assign s_off  = s_cyc && !dma_on;
   assign hs1_ok = dma_on && same && state == PTR &&
                   cycle_type == VIC_HS1;
   assign ls2_ok = dma_on && same && state == B0 &&
                   cycle_type == VIC_LS2;
   assign hs3_ok = dma_on && same && state == B1 &&
                   cycle_type == VIC_HS3;
   assign s_bad  = s_cyc && dma_on &&
                   !(hs1_ok || ls2_ok || hs3_ok);

   always_ff @(posedge clk_dot4x) begin
      if (!rst_n) begin
         state         <= IDLE;
         cur           <= '0;
         stage         <= '0;
         fetch_done    <= '0;
         fetch_seq_err <= 1'b0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            ptr_q[i] <= '0;
            pix_q[i] <= '0;
         end
      end else begin
         fetch_done <= '0;
         if (phi_phase_start_dav) begin
            unique case (1'b1)
               lp: begin
                  ptr_q[sprite_cnt] <= dbi;
                  cur               <= sprite_cnt;
                  state             <= PTR;
               end
               idle_f: state <= IDLE;
               s_off: begin
                  stage <= '0;
                  state <= IDLE;
               end
               hs1_ok: begin
                  stage[23:16] <= dbi;
                  state        <= B0;
               end
               ls2_ok: begin
                  stage[15:8] <= dbi;
                  state       <= B1;
               end
               hs3_ok: begin
                  pix_q[cur]      <= {stage, dbi};
                  fetch_done[cur] <= 1'b1;
                  state           <= IDLE;
               end
               s_bad: begin
                  fetch_seq_err <= 1'b1;
                  stage         <= '0;
                  state         <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: vector table plus scoreboard.
module tb_sprite_fetch;
   import sprite_fetch_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   cycle_type;
   logic [2:0]   sprite_cnt;
   logic         dav;
   logic [7:0]   sprite_dma;
   logic [47:0]  sprite_mc;
   logic [3:0]   vm;
   logic [7:0]   dbi;
   logic [13:0]  sprite_addr;
   logic         sprite_addr_valid;
   logic [63:0]  sprite_ptr;
   logic [191:0] sprite_pixels;
   logic [7:0]   fetch_done;
   logic         fetch_seq_err;

   always #5 clk = ~clk;

   sprite_fetch dut (
      .clk_dot4x           (clk),
      .rst_n               (rst_n),
      .cycle_type          (cycle_type),
      .sprite_cnt          (sprite_cnt),
      .phi_phase_start_dav (dav),
      .sprite_dma          (sprite_dma),
      .sprite_mc           (sprite_mc),
      .vm                  (vm),
      .dbi                 (dbi),
      .sprite_addr         (sprite_addr),
      .sprite_addr_valid   (sprite_addr_valid),
      .sprite_ptr          (sprite_ptr),
      .sprite_pixels       (sprite_pixels),
      .fetch_done          (fetch_done),
      .fetch_seq_err       (fetch_seq_err)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          spr;
      logic [23:0] pix;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      int          spr;
      logic [3:0]  vm;
      logic [7:0]  ptr;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [5:0]  mc;
      logic        dma;
      logic [13:0] lp_addr;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [23:0] pix(input int n);
      return sprite_pixels[n*24 +: 24];
   endfunction

   function automatic logic [7:0] ptr(input int n);
      return sprite_ptr[n*8 +: 8];
   endfunction

   // Scoreboard: every fetch_done pulse must match the next expected commit.
   always @(negedge clk) begin
      if (rst_n && fetch_done != 8'h00) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(fetch_done), 32'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("done_onehot", 32'(fetch_done), 32'h1 << mon_e.spr);
            chk("commit_pixels", 32'(pix(mon_e.spr)), 32'(mon_e.pix));
         end
      end
   end

   // One half-cycle: 4 ticks, dav on the second, sampled at negedges.
   task automatic half(input logic [3:0] ct, input int cnt,
                       input logic [7:0] d, output logic [13:0] a,
                       output logic v, output logic [7:0] d1,
                       output logic [7:0] d2);
      cycle_type = ct;
      sprite_cnt = 3'(cnt);
      dbi        = d;
      dav        = 1'b0;
      @(negedge clk);
      a   = sprite_addr;
      v   = sprite_addr_valid;
      dav = 1'b1;
      @(negedge clk);
      dav = 1'b0;
      d1  = fetch_done;
      @(negedge clk);
      d2 = fetch_done;
      @(negedge clk);
   endtask

   task automatic hq(input logic [3:0] ct, input int cnt,
                     input logic [7:0] d);
      logic [13:0] a;
      logic        v;
      logic [7:0]  d1, d2;
      half(ct, cnt, d, a, v, d1, d2);
   endtask

   task automatic do_fetch(input vec_t t);
      logic [13:0] a;
      logic        v;
      logic [7:0]  d1, d2;
      logic [23:0] old;
      logic [7:0]  bytes [3];
      logic [3:0]  st [3];
      logic [5:0]  m;
      exp_t        e;
      bytes[0] = t.b0;
      bytes[1] = t.b1;
      bytes[2] = t.b2;
      st[0] = VIC_HS1;
      st[1] = VIC_LS2;
      st[2] = VIC_HS3;
      vm = t.vm;
      sprite_dma[t.spr] = t.dma;
      half(VIC_LP, t.spr, t.ptr, a, v, d1, d2);
      chk("lp_addr", 32'(a), 32'(t.lp_addr));
      chk("lp_valid", 32'(v), 32'h1);
      chk("ptr_latched", 32'(ptr(t.spr)), 32'(t.ptr));
      old = pix(t.spr);
      for (int k = 0; k < 3; k++) begin
         m = t.mc + 6'(k);
         sprite_mc[t.spr*6 +: 6] = m;
         if (k == 2 && t.dma) begin
            e.spr = t.spr;
            e.pix = {t.b0, t.b1, t.b2};
            sb.push_back(e);
         end
         half(st[k], t.spr, bytes[k], a, v, d1, d2);
         chk("s_valid", 32'(v), 32'(t.dma));
         chk("s_addr", 32'(a),
             t.dma ? 32'({t.ptr, m}) : 32'(t.lp_addr));
      end
      if (t.dma) begin
         chk("done_pulse", 32'(d1), 32'h1 << t.spr);
         chk("done_one_tick", 32'(d2), 32'h0);
      end else begin
         chk("dma_off_pix", 32'(pix(t.spr)), 32'(old));
         chk("dma_off_err", 32'(fetch_seq_err), 32'h0);
      end
   endtask

   task automatic chk_reset();
      for (int n = 0; n < 8; n++) begin
         chk("rst_pix", 32'(pix(n)), 32'h0);
         chk("rst_ptr", 32'(ptr(n)), 32'h0);
      end
      chk("rst_addr", 32'(sprite_addr), 32'h0);
      chk("rst_valid", 32'(sprite_addr_valid), 32'h0);
      chk("rst_done", 32'(fetch_done), 32'h0);
      chk("rst_err", 32'(fetch_seq_err), 32'h0);
   endtask

   initial begin
      logic [23:0] o2, o4;
      vec_t        t;
      logic [13:0] a;
      logic        v;
      logic [7:0]  d1, d2;

      vecs[0] = '{3, 4'h1, 8'h80, 8'hAA, 8'h55, 8'hF0, 6'd0,  1'b1, 14'h07FB};
      vecs[1] = '{5, 4'h2, 8'h3C, 8'h11, 8'h22, 8'h33, 6'd16, 1'b0, 14'h0BFD};
      vecs[2] = '{0, 4'hF, 8'hFF, 8'h01, 8'h02, 8'h03, 6'd63, 1'b1, 14'h3FF8};
      vecs[3] = '{7, 4'h0, 8'h00, 8'hDE, 8'hAD, 8'hBE, 6'd32, 1'b1, 14'h03FF};

      rst_n      = 1'b0;
      cycle_type = VIC_HIDLE;
      sprite_cnt = 3'd0;
      dav        = 1'b0;
      sprite_dma = 8'h00;
      sprite_mc  = '0;
      vm         = 4'h0;
      dbi        = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) do_fetch(vecs[i]);

      // DMA drops after HS1: silent abort
      sprite_dma[1] = 1'b1;
      o2 = pix(1);
      hq(VIC_LP, 1, 8'h12);
      hq(VIC_HS1, 1, 8'h99);
      sprite_dma[1] = 1'b0;
      hq(VIC_LS2, 1, 8'h98);
      hq(VIC_HS3, 1, 8'h97);
      chk("drop_err", 32'(fetch_seq_err), 32'h0);
      chk("drop_pix", 32'(pix(1)), 32'(o2));
      chk("drop_stage", 32'(dut.stage), 32'h0);

      // Fresh LP while in B1 restarts without error
      sprite_dma[2] = 1'b1;
      hq(VIC_LP, 2, 8'h01);
      hq(VIC_HS1, 2, 8'h77);
      hq(VIC_LS2, 2, 8'h66);
      t = '{2, 4'h3, 8'h21, 8'hC1, 8'hC2, 8'hC3, 6'd5, 1'b1, 14'h0FFA};
      do_fetch(t);
      chk("restart_err", 32'(fetch_seq_err), 32'h0);

      // Back-to-back window, sprites 0..7
      for (int n = 0; n < 8; n++) begin
         t.spr     = n;
         t.vm      = 4'hA;
         t.ptr     = 8'h40 + 8'(n);
         t.b0      = 8'h10 + 8'(n);
         t.b1      = 8'h20 + 8'(n);
         t.b2      = 8'h30 + 8'(n);
         t.mc      = 6'(n * 4);
         t.dma     = 1'b1;
         t.lp_addr = {4'hA, 7'h7F, 3'(n)};
         do_fetch(t);
      end
      for (int n = 0; n < 8; n++) begin
         chk("b2b_hold", 32'(pix(n)),
             32'({8'h10 + 8'(n), 8'h20 + 8'(n), 8'h30 + 8'(n)}));
      end
      chk("b2b_err", 32'(fetch_seq_err), 32'h0);

      // sprite_cnt jumps 2 -> 4 before HS3
      sprite_dma = 8'hFF;
      o2 = pix(2);
      o4 = pix(4);
      hq(VIC_LP, 2, 8'h50);
      hq(VIC_HS1, 2, 8'hE1);
      hq(VIC_LS2, 2, 8'hE2);
      half(VIC_HS3, 4, 8'hE3, a, v, d1, d2);
      chk("seq_err_set", 32'(fetch_seq_err), 32'h1);
      chk("seq_pix2", 32'(pix(2)), 32'(o2));
      chk("seq_pix4", 32'(pix(4)), 32'(o4));
      chk("seq_no_done", 32'(d1), 32'h0);
      hq(VIC_HIDLE, 0, 8'h00);
      chk("err_sticky", 32'(fetch_seq_err), 32'h1);

      // Reset while in B1 aborts the fetch
      hq(VIC_LP, 6, 8'h66);
      hq(VIC_HS1, 6, 8'hA1);
      hq(VIC_LS2, 6, 8'hA2);
      cycle_type = VIC_HIDLE;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      half(VIC_HS3, 6, 8'hA3, a, v, d1, d2);
      chk("post_rst_no_done", 32'(d1), 32'h0);
      chk("post_rst_pix", 32'(pix(6)), 32'h0);

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
